// File: rtl/pcs25g_sync_pkg.sv
// Shared constants, helpers and parameter-check macro for the PCS sync cells.
// Chain depth and filter length are range-checked at elaboration by every user.
`ifndef PCS25G_SYNC_PKG_SV
`define PCS25G_SYNC_PKG_SV

`define PCS25G_SYNC_PARAM_CHECK(label, cond) \
    if (!(cond)) begin : label \
        $error("pcs25g_sync: parameter out of legal range"); \
    end

package pcs25g_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int FILT_CYCLES_MAX = 255;

    // IDLE: synchronised level matches dout; PENDING: a new level is being timed.
    typedef enum logic {
        CH_IDLE    = 1'b0,
        CH_PENDING = 1'b1
    } chan_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`endif

// File: rtl/sync_filt_chan.sv
// One channel: STAGES-deep synchroniser chain, stability filter and edge strobes.
// edge_next is exported so the parent can register any_edge alongside the strobes.
module sync_filt_chan
    import pcs25g_sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 1,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic edge_next
);

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0] chain_reg;

    logic        s;
    logic        commit;
    chan_state_e state;
    logic        dout_reg;
    logic        dout_next;
    logic        rise_reg;
    logic        rise_next;
    logic        fall_reg;
    logic        fall_next;

    // Pure flop-to-flop chain: nothing may sit between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {STAGES{RESET_VAL}};
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
        end
    end

    assign s     = chain_reg[STAGES-1];
    assign state = (s == dout_reg) ? CH_IDLE : CH_PENDING;

    if (FILT_CYCLES == 1) begin : g_nofilt
        assign commit = (state == CH_PENDING);
    end else begin : g_filt
        localparam int               CNT_W    = clog2(FILT_CYCLES);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;

        // Counter clears on revert (IDLE) and on commit; otherwise it advances.
        always_comb begin
            cnt_next = '0;
            if ((state == CH_PENDING) && (cnt_reg != CNT_LAST)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        assign commit = (state == CH_PENDING) && (cnt_reg == CNT_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end
    end

    always_comb begin
        dout_next = dout_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (commit) begin
            dout_next = s;
            rise_next = s;
            fall_next = ~s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg <= RESET_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            dout_reg <= dout_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    assign dout      = dout_reg;
    assign rise      = rise_reg;
    assign fall      = fall_reg;
    assign edge_next = rise_next | fall_next;

endmodule

// File: rtl/sync_nxdff_filt.sv
// WIDTH independent synchroniser/filter channels plus a registered any_edge flag.
// Channels carry no mutual coherency; any_edge lines up with the per-bit strobes.
module sync_nxdff_filt
    import pcs25g_sync_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter int               FILT_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_edge
);

    `PCS25G_SYNC_PARAM_CHECK(g_chk_width, WIDTH >= 1)
    `PCS25G_SYNC_PARAM_CHECK(g_chk_stages, (STAGES >= SYNC_STAGES_MIN) && (STAGES <= SYNC_STAGES_MAX))
    `PCS25G_SYNC_PARAM_CHECK(g_chk_filt, (FILT_CYCLES >= 1) && (FILT_CYCLES <= FILT_CYCLES_MAX))

    logic [WIDTH-1:0] edge_next;
    logic             any_edge_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        sync_filt_chan #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_VAL   (RESET_VAL[gi])
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .din       (din[gi]),
            .dout      (dout[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi]),
            .edge_next (edge_next[gi])
        );
    end

    // Built from the channels' next-strobe terms so it asserts with them, not a cycle late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_edge_reg <= 1'b0;
        end else begin
            any_edge_reg <= |edge_next;
        end
    end

    assign any_edge = any_edge_reg;

endmodule

// File: tb/tb_sync_nxdff_filt.sv
// Directed bench: several parameterisations of sync_nxdff_filt sharing clk/rst_n.
// Expected values are hand-derived from the latency STAGES-1+FILT_CYCLES after the sample edge.
module tb_sync_nxdff_filt;

    logic clk;
    logic rst_n;

    // a: WIDTH=4 STAGES=2 FILT=3 (reset + mid-pending reset)
    logic [3:0] din_a, dout_a, rise_a, fall_a;
    logic       any_a;
    // b: WIDTH=1 STAGES=2 FILT=4 (glitch rejection)
    logic       din_b, dout_b, rise_b, fall_b, any_b;
    // c: WIDTH=1 STAGES=3 FILT=1 (bypass)
    logic       din_c, dout_c, rise_c, fall_c, any_c;
    // d: WIDTH=1 STAGES=2 FILT=5 (chatter)
    logic       din_d, dout_d, rise_d, fall_d, any_d;
    // e: WIDTH=8 STAGES=2 FILT=2 (simultaneous edges)
    logic [7:0] din_e, dout_e, rise_e, fall_e;
    logic       any_e;

    int checks = 0;
    int errors = 0;

    sync_nxdff_filt #(.WIDTH(4), .STAGES(2), .FILT_CYCLES(3), .RESET_VAL(4'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .dout(dout_a), .rise(rise_a), .fall(fall_a), .any_edge(any_a));
    sync_nxdff_filt #(.WIDTH(1), .STAGES(2), .FILT_CYCLES(4), .RESET_VAL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .dout(dout_b), .rise(rise_b), .fall(fall_b), .any_edge(any_b));
    sync_nxdff_filt #(.WIDTH(1), .STAGES(3), .FILT_CYCLES(1), .RESET_VAL(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .dout(dout_c), .rise(rise_c), .fall(fall_c), .any_edge(any_c));
    sync_nxdff_filt #(.WIDTH(1), .STAGES(2), .FILT_CYCLES(5), .RESET_VAL(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .din(din_d), .dout(dout_d), .rise(rise_d), .fall(fall_d), .any_edge(any_d));
    sync_nxdff_filt #(.WIDTH(8), .STAGES(2), .FILT_CYCLES(2), .RESET_VAL(8'h00)) u_e (
        .clk(clk), .rst_n(rst_n), .din(din_e), .dout(dout_e), .rise(rise_e), .fall(fall_e), .any_edge(any_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic byp_d(input int k);
        return ((k / 4) % 2) == 0;
    endfunction

    task automatic test_reset();
        logic [3:0] exp_dout, exp_rise;
        logic       exp_any;
        rst_n = 1'b0;
        din_a = 4'hF;
        tick();
        tick();
        checks++; if (dout_a !== 4'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout_a); end
        checks++; if (rise_a !== 4'h0) begin errors++; $display("FAIL reset_rise: got %h expected 0", rise_a); end
        checks++; if (fall_a !== 4'h0) begin errors++; $display("FAIL reset_fall: got %h expected 0", fall_a); end
        checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected 0", any_a); end
        rst_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            exp_dout = (k >= 4) ? 4'hF : 4'h0;
            exp_rise = (k == 4) ? 4'hF : 4'h0;
            exp_any  = (k == 4);
            checks++; if (dout_a !== exp_dout) begin errors++; $display("FAIL release_dout k=%0d: got %h expected %h", k, dout_a, exp_dout); end
            checks++; if (rise_a !== exp_rise) begin errors++; $display("FAIL release_rise k=%0d: got %h expected %h", k, rise_a, exp_rise); end
            checks++; if (fall_a !== 4'h0) begin errors++; $display("FAIL release_fall k=%0d: got %h expected 0", k, fall_a); end
            checks++; if (any_a !== exp_any) begin errors++; $display("FAIL release_any k=%0d: got %b expected %b", k, any_a, exp_any); end
        end
        $display("test_reset: din=F after release, dout=%h", dout_a);
    endtask

    task automatic test_glitch();
        // 3-cycle pulse: rejected
        din_b = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 2) din_b = 1'b0;
            checks++; if (dout_b !== 1'b0) begin errors++; $display("FAIL glitch3_dout k=%0d: got %b expected 0", k, dout_b); end
            checks++; if (rise_b !== 1'b0) begin errors++; $display("FAIL glitch3_rise k=%0d: got %b expected 0", k, rise_b); end
        end
        $display("test_glitch: 3-cycle pulse, dout=%b", dout_b);
        // 4-cycle pulse: accepted, then low level filtered for 4 cycles
        din_b = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 3) din_b = 1'b0;
            checks++; if (dout_b !== ((k >= 5) && (k <= 8))) begin errors++; $display("FAIL glitch4_dout k=%0d: got %b expected %b", k, dout_b, ((k >= 5) && (k <= 8))); end
            checks++; if (rise_b !== (k == 5)) begin errors++; $display("FAIL glitch4_rise k=%0d: got %b expected %b", k, rise_b, (k == 5)); end
            checks++; if (fall_b !== (k == 9)) begin errors++; $display("FAIL glitch4_fall k=%0d: got %b expected %b", k, fall_b, (k == 9)); end
            checks++; if (any_b !== ((k == 5) || (k == 9))) begin errors++; $display("FAIL glitch4_any k=%0d: got %b expected %b", k, any_b, ((k == 5) || (k == 9))); end
        end
        $display("test_glitch: 4-cycle pulse, dout=%b", dout_b);
    endtask

    task automatic test_bypass();
        logic exp_dout, prev_dout;
        for (int k = 0; k < 24; k++) begin
            din_c = byp_d(k);
            tick();
            exp_dout  = (k >= 3) ? byp_d(k - 3) : 1'b0;
            prev_dout = (k >= 4) ? byp_d(k - 4) : 1'b0;
            checks++; if (dout_c !== exp_dout) begin errors++; $display("FAIL bypass_dout k=%0d: got %b expected %b", k, dout_c, exp_dout); end
            checks++; if (rise_c !== (exp_dout & ~prev_dout)) begin errors++; $display("FAIL bypass_rise k=%0d: got %b expected %b", k, rise_c, exp_dout & ~prev_dout); end
            checks++; if (fall_c !== (~exp_dout & prev_dout)) begin errors++; $display("FAIL bypass_fall k=%0d: got %b expected %b", k, fall_c, ~exp_dout & prev_dout); end
        end
        $display("test_bypass: 24 cycles toggling period 8, dout=%b", dout_c);
    endtask

    task automatic test_chatter();
        for (int k = 0; k <= 14; k++) begin
            din_d = (k < 4) ? ((k % 2) == 0) : 1'b1;
            tick();
            checks++; if (dout_d !== (k >= 10)) begin errors++; $display("FAIL chatter_dout k=%0d: got %b expected %b", k, dout_d, (k >= 10)); end
            checks++; if (rise_d !== (k == 10)) begin errors++; $display("FAIL chatter_rise k=%0d: got %b expected %b", k, rise_d, (k == 10)); end
            checks++; if (fall_d !== 1'b0) begin errors++; $display("FAIL chatter_fall k=%0d: got %b expected 0", k, fall_d); end
        end
        $display("test_chatter: 1,0,1,0 then hold 1, dout=%b", dout_d);
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_dout, exp_rise, exp_fall;
        din_e = 8'h0F;
        repeat (6) tick();
        checks++; if (dout_e !== 8'h0F) begin errors++; $display("FAIL simul_pre_dout: got %h expected 0f", dout_e); end
        din_e = 8'hF0;
        for (int k = 0; k <= 5; k++) begin
            tick();
            exp_dout = (k >= 3) ? 8'hF0 : 8'h0F;
            exp_rise = (k == 3) ? 8'hF0 : 8'h00;
            exp_fall = (k == 3) ? 8'h0F : 8'h00;
            checks++; if (dout_e !== exp_dout) begin errors++; $display("FAIL simul_dout k=%0d: got %h expected %h", k, dout_e, exp_dout); end
            checks++; if (rise_e !== exp_rise) begin errors++; $display("FAIL simul_rise k=%0d: got %h expected %h", k, rise_e, exp_rise); end
            checks++; if (fall_e !== exp_fall) begin errors++; $display("FAIL simul_fall k=%0d: got %h expected %h", k, fall_e, exp_fall); end
            checks++; if (any_e !== (k == 3)) begin errors++; $display("FAIL simul_any k=%0d: got %b expected %b", k, any_e, (k == 3)); end
        end
        $display("test_simultaneous: 0f->f0, dout=%h", dout_e);
    endtask

    task automatic test_mid_pending_reset();
        logic [3:0] exp_dout, exp_rise;
        din_a = 4'h0;
        tick();
        tick();
        tick();
        // s has differed from dout for one edge: cnt == FILT_CYCLES-2
        checks++; if (dout_a !== 4'hF) begin errors++; $display("FAIL midrst_pending_dout: got %h expected f", dout_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (dout_a !== 4'h0) begin errors++; $display("FAIL midrst_dout: got %h expected 0", dout_a); end
        checks++; if (rise_a !== 4'h0) begin errors++; $display("FAIL midrst_rise: got %h expected 0", rise_a); end
        checks++; if (fall_a !== 4'h0) begin errors++; $display("FAIL midrst_fall: got %h expected 0", fall_a); end
        checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL midrst_any: got %b expected 0", any_a); end
        din_a = 4'hF;
        tick();
        tick();
        checks++; if (dout_a !== 4'h0) begin errors++; $display("FAIL midrst_held_dout: got %h expected 0", dout_a); end
        rst_n = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            tick();
            exp_dout = (k >= 4) ? 4'hF : 4'h0;
            exp_rise = (k == 4) ? 4'hF : 4'h0;
            checks++; if (dout_a !== exp_dout) begin errors++; $display("FAIL midrst_rel_dout k=%0d: got %h expected %h", k, dout_a, exp_dout); end
            checks++; if (rise_a !== exp_rise) begin errors++; $display("FAIL midrst_rel_rise k=%0d: got %h expected %h", k, rise_a, exp_rise); end
            checks++; if (fall_a !== 4'h0) begin errors++; $display("FAIL midrst_rel_fall k=%0d: got %h expected 0", k, fall_a); end
            checks++; if (any_a !== (k == 4)) begin errors++; $display("FAIL midrst_rel_any k=%0d: got %b expected %b", k, any_a, (k == 4)); end
        end
        $display("test_mid_pending_reset: reset during count, dout=%h", dout_a);
    endtask

    initial begin
        rst_n = 1'b0;
        din_a = 4'h0;
        din_b = 1'b0;
        din_c = 1'b0;
        din_d = 1'b0;
        din_e = 8'h00;
        test_reset();
        test_glitch();
        test_bypass();
        test_chatter();
        test_simultaneous();
        test_mid_pending_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sync_nxdff_filt.md
# sync_nxdff_filt

Parametrised multi-bit synchroniser with per-channel glitch filter and edge detection. Brings `WIDTH` independent, mutually asynchronous level signals into the `clk` domain: PCS status pins, link/lock flags, and sideband control bits. Each bit passes through a `STAGES`-deep flop chain and then a stability filter that rejects pulses shorter than `FILT_CYCLES`. Single-cycle rise/fall strobes are provided for downstream event logic.

## Interface
Parameters:
- `WIDTH`, 1: number of independent channels.
- `STAGES`, 2: synchroniser chain depth. Legal range 2..4.
- `FILT_CYCLES`, 1: consecutive cycles a new synchronised level must hold before `dout` follows it. Legal range 1..255. 1 means no filtering.
- `RESET_VAL`, {WIDTH{1'b0}}: reset value of the chain flops and of `dout`.

Ports:
- `clk` in 1: destination clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `din` in WIDTH: asynchronous inputs. No timing relationship to `clk`.
- `dout` out WIDTH: filtered, synchronised level.
- `rise` out WIDTH: one-cycle strobe when `dout[i]` goes 0→1.
- `fall` out WIDTH: one-cycle strobe when `dout[i]` goes 1→0.
- `any_edge` out 1: registered OR of all `rise|fall`, asserted the same cycle as those strobes.

## Operation
- Channels are fully independent. There is no cross-bit coherency; multi-bit buses needing coherency use a handshake synchroniser instead.
- Per channel, `s` is the last chain stage. The chain shifts every clock.
- Per channel, the filter counter `cnt` has width clog2(FILT_CYCLES). For FILT_CYCLES=1 the counter is absent and compare-to-0 is always true.
- If `s == dout`: `cnt <= 0`.
- Else if `cnt == FILT_CYCLES-1`: `dout <= s`, `cnt <= 0`, and assert `rise` or `fall` per the new value for one cycle.
- Else: `cnt <= cnt+1`.
- The counter restarts whenever `s` returns to `dout`. A run of new values shorter than `FILT_CYCLES` cycles at `s` produces no change on `dout` and no strobe.
- Effective state per channel is IDLE (s==dout) or PENDING (cnt counting). The transition to IDLE happens on commit or on revert.
- Reset values:
  - chain = RESET_VAL
  - `dout` = RESET_VAL
  - `cnt` = 0
  - `rise` = `fall` = 0
  - `any_edge` = 0
- No strobe is generated by reset assertion or release, even if `din` differs from RESET_VAL. A difference after release is filtered and reported as a normal edge.

## Timing
- Latency: when `din[i]` changes and is captured by stage 0 on edge E0 (metastability permitting), `dout[i]` updates on edge E0 + STAGES - 1 + FILT_CYCLES.
- Metastability can add ±1 cycle of uncertainty at the first stage. Benches allow this window.
- `rise`/`fall`/`any_edge` assert on the same edge `dout` changes and drop on the next edge. Back-to-back edges are therefore separated by at least FILT_CYCLES cycles.
- Simultaneous edges on several channels: each strobe is independent and `any_edge` asserts once.
- Reset asserted mid-PENDING: the count is discarded and the channel restarts from RESET_VAL after release.
- Chain flops carry the `ASYNC_REG`/dont-touch attributes used by the existing sync cells. No logic is allowed between chain stages.

## Structure
- Package `pcs25g_sync_pkg`:
  - `clog2` helper function.
  - Legal-range constants `SYNC_STAGES_MIN`/`MAX` and `FILT_CYCLES_MAX`.
  - Elaboration-time assertion macros on the parameters.
- One sub-module, `sync_filt_chan`: a single-bit chain plus filter plus edge strobe. It is instantiated WIDTH times with a generate loop.
- The top level adds only the `any_edge` OR-reduce register.

## Test plan
- Reset with `din`=1, RESET_VAL=0, WIDTH=4: during reset `dout`=0 and all strobes 0. After release with `din`=4'hF, STAGES=2, FILT_CYCLES=3, `dout`=4'hF exactly 4 edges after the first sample edge. `rise`=4'hF for one cycle and `any_edge`=1 for one cycle.
- Glitch rejection, FILT_CYCLES=4: a 3-cycle high pulse on `din[0]` leaves `dout[0]`=0 with no strobe. A 4-cycle pulse produces `dout[0]`=1 plus `rise[0]`, and later `fall[0]` after the low level has held 4 cycles.
- Bypass, FILT_CYCLES=1, STAGES=3: a toggling `din` (period 8 clocks) appears on `dout` 3 edges later. Each edge gives exactly one strobe.
- Chatter: `din` toggles 1,0,1,0 each cycle then holds 1, with FILT_CYCLES=5. `cnt` restarts each time. `dout` rises exactly 5 cycles after the last toggle, with a single `rise`.
- Simultaneous edges: `din` goes 8'h0F→8'hF0 in one cycle. `rise`=8'hF0 and `fall`=8'h0F on the same cycle, and `any_edge` is a single one-cycle pulse.
- Mid-PENDING reset: assert `rst_n` low while a channel is at cnt=FILT_CYCLES-2. All outputs immediately return to reset values with no strobe. After release the bench confirms the normal latency.
